ddr3_axis_cmd_parser: RTL and testbench
=======================================

DDR3_AXIS_CMD_PARSER -- requirements
Module: ddr3_axis_cmd_parser

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 27, word-address width of req_addr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, write-data width; only 32 is supported (4 bytes per word).
REQ-003 SHALL have ports `clock` (in, 1, sole clock) and `arst_n` (in, 1, asynchronous active-low reset).
REQ-004 SHALL have ports `s_tvalid`/`s_tready`/`s_tlast`/`s_tkeep` (in/out/in/in, 1 each) and `s_tdata` (in, 8): the USB bulk-OUT byte stream.
REQ-005 SHALL have ports `req_valid` (out, 1), `req_ready` (in, 1), `req_write` (out, 1), `req_addr` (out, ADDR_WIDTH) and `req_len` (out, 8, words minus 1).
REQ-006 SHALL have ports `wr_valid` (out, 1), `wr_ready` (in, 1), `wr_last` (out, 1), `wr_mask` (out, 4, byte enables) and `wr_data` (out, 32).
REQ-007 SHALL have ports `err_o` (out, 1, one-cycle pulse), `cmd_count_o` (out, 16) and `err_count_o` (out, 16).

Function
REQ-008 SHALL parse each packet as a header: byte0 opcode (0x01 WRITE, 0x02 READ); bytes1-4 address, big-endian, low ADDR_WIDTH bits kept; byte5 LEN (words = LEN+1).
REQ-009 SHALL count and consume only beats where s_tvalid&&s_tready&&s_tkeep; keep=0 beats are accepted and ignored, but their tlast still counts.
REQ-010 SHALL implement states IDLE, ADDR, LEN, REQ, DATA, WORD, DROP.
REQ-011 IDLE: on valid opcode go to ADDR; on any other opcode go to DROP (or stay in IDLE if tlast), pulsing err_o.
REQ-012 ADDR: after 4 bytes go to LEN; LEN: on its byte go to REQ, with req_valid high in the following cycle.
REQ-013 SHALL hold req_valid and all req_* fields stable until req_ready; s_tready SHALL be 0 in REQ.
REQ-014 After the request handshake: READ goes to IDLE if tlast was on the LEN byte, otherwise to DROP with err_o; WRITE goes to DATA.
REQ-015 DATA: SHALL pack bytes little-endian (first byte to wr_data[7:0]); after 4 bytes go to WORD with wr_valid high the next cycle and wr_mask=4'hF.
REQ-016 WORD: s_tready=0; wr_valid and its fields SHALL stay stable until wr_ready; on the last word assert wr_last and then go to IDLE (or DROP if tlast not yet seen, with err_o).
REQ-017 On tlast in DATA before the word count is reached, SHALL emit the partial word (mask bits set only for the bytes filled) with wr_last=1, pulse err_o, and return to IDLE.
REQ-018 If tlast arrives in DATA on a word boundary with words still due, SHALL emit one word with wr_mask=0 and wr_last=1, plus err_o.
REQ-019 On tlast in ADDR or LEN, SHALL issue no request, pulse err_o, and go to IDLE.
REQ-020 DROP: s_tready=1, bytes discarded; SHALL go to IDLE on tlast.
REQ-021 s_tready SHALL be 1 in IDLE, ADDR, LEN, DATA and DROP.
REQ-022 cmd_count_o SHALL increment on each req handshake and err_count_o on each err_o pulse; both saturate at 16'hFFFF.

Reset
REQ-023 On arst_n low: state=IDLE; s_tready, req_valid, wr_valid, wr_last, err_o=0; req_*, wr_data, wr_mask=0; counters=0.
REQ-024 Mid-transfer reset SHALL abandon the packet immediately, with no partial word emitted; after release, parsing resumes at the next byte treated as an opcode.

Configuration
REQ-025 With CMD_PARSER_STATS_EN defined, cmd_count_o and err_count_o SHALL be implemented per REQ-022.
REQ-026 Without CMD_PARSER_STATS_EN, both ports SHALL be constant 0 with no counter registers; err_o is unaffected.

Structure
REQ-027 Opcode constants, header length (6), and state encodings SHALL live in shared package/include ddr3_cmd_pkg.
REQ-028 Byte-to-word packing (shift register, byte index, mask) SHALL be sub-module axis_byte_packer.

Verification
REQ-029 WRITE 01 00 00 01 00 01 + 8 bytes 11..88, tlast on last: one req (write=1, addr=0x100, len=1), then words 0x44332211 and 0x88776655 (wr_last on second), mask F.
REQ-030 READ 02 00 00 00 40 07 with tlast on byte5: req write=0, addr=0x40, len=7; no wr beats; err_o stays 0.
REQ-031 WRITE LEN=1 truncated after 6 payload bytes: second word mask 4'b0011 with wr_last=1, err_o pulses once.
REQ-032 Opcode 0x55 with a 10-byte packet: all bytes accepted, no req, err_o=1, err_count_o=1.
REQ-033 Hold req_ready=0 for 20 cycles, then wr_ready toggling 1-of-3: fields stable and s_tready=0 while stalled; data matches REQ-029.
REQ-034 arst_n pulse mid-DATA: outputs reach reset values; a following valid READ packet is parsed correctly.

Source files
------------

// File: rtl/ddr3_cmd_pkg.sv
// Shared definitions for the DDR3 AXIS command parser: opcodes, header size,
// FSM state encoding and the saturating counter helper.
package ddr3_cmd_pkg;

  localparam logic [7:0] OP_WRITE   = 8'h01;
  localparam logic [7:0] OP_READ    = 8'h02;
  localparam int         HDR_LEN    = 6;
  localparam int         WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_REQ,
    ST_DATA,
    ST_WORD,
    ST_DROP
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/axis_byte_packer.sv
// Packs bytes little-endian into a 32-bit word and tracks which lanes hold data.
// fill_o flags the push that completes the word.
module axis_byte_packer
  import ddr3_cmd_pkg::*;
(
  input  logic                    clock,
  input  logic                    arst_n,
  input  logic                    clr_i,
  input  logic                    push_i,
  input  logic [7:0]              byte_i,
  output logic                    fill_o,
  output logic [8*WORD_BYTES-1:0] data_o,
  output logic [WORD_BYTES-1:0]   mask_o
);

  logic [8*WORD_BYTES-1:0] data_q, data_d;
  logic [WORD_BYTES-1:0]   mask_q, mask_d;
  logic [1:0]              idx_q, idx_d;

  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    idx_d  = idx_q;
    if (clr_i) begin
      data_d = '0;
      mask_d = '0;
      idx_d  = '0;
    end else if (push_i) begin
      data_d[{idx_q, 3'b000} +: 8] = byte_i;
      mask_d[idx_q]                = 1'b1;
      idx_d                        = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      data_q <= '0;
      mask_q <= '0;
      idx_q  <= '0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      idx_q  <= idx_d;
    end
  end

  assign fill_o = push_i && (idx_q == 2'd3);
  assign data_o = data_q;
  assign mask_o = mask_q;

endmodule

// File: rtl/ddr3_axis_cmd_parser.sv
// Parses USB bulk-OUT byte packets into DDR3 read/write requests plus write words.
// Define CMD_PARSER_STATS_EN to build the saturating command/error counters.
module ddr3_axis_cmd_parser
  import ddr3_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    arst_n,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  input  logic                    s_tkeep,
  input  logic [7:0]              s_tdata,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic                    req_write,
  output logic [ADDR_WIDTH-1:0]   req_addr,
  output logic [7:0]              req_len,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic                    wr_last,
  output logic [DATA_WIDTH/8-1:0] wr_mask,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    err_o,
  output logic [15:0]             cmd_count_o,
  output logic [15:0]             err_count_o
);

  state_t                state_q, state_d;
  logic                  s_tready_q, s_tready_d;
  logic [2:0]            hdr_cnt_q, hdr_cnt_d;
  logic                  req_valid_q, req_valid_d;
  logic                  req_write_q, req_write_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [7:0]            req_len_q, req_len_d;
  logic                  wr_valid_q, wr_valid_d;
  logic                  wr_last_q, wr_last_d;
  logic [7:0]            word_q, word_d;
  logic                  last_seen_q, last_seen_d;
  logic                  err_q, err_d;
  logic                  beat, last_word;
  logic                  pk_push, pk_clr, pk_fill;

  assign beat      = s_tvalid && s_tready_q;
  assign last_word = (word_q == req_len_q);

  axis_byte_packer u_packer (
    .clock  (clock),
    .arst_n (arst_n),
    .clr_i  (pk_clr),
    .push_i (pk_push),
    .byte_i (s_tdata),
    .fill_o (pk_fill),
    .data_o (wr_data),
    .mask_o (wr_mask)
  );

  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    req_valid_d = req_valid_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_len_d   = req_len_q;
    wr_valid_d  = wr_valid_q;
    wr_last_d   = wr_last_q;
    word_d      = word_q;
    last_seen_d = last_seen_q;
    err_d       = 1'b0;
    pk_push     = 1'b0;
    pk_clr      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // keep=0 beats are ignored here, including their tlast
        if (beat && s_tkeep) begin
          last_seen_d = 1'b0;
          if ((s_tdata == OP_WRITE) || (s_tdata == OP_READ)) begin
            if (s_tlast) begin
              err_d = 1'b1;
            end else begin
              req_write_d = (s_tdata == OP_WRITE);
              req_addr_d  = '0;
              hdr_cnt_d   = 3'd1;
              state_d     = ST_ADDR;
            end
          end else begin
            err_d = 1'b1;
            if (!s_tlast) state_d = ST_DROP;
          end
        end
      end
      ST_ADDR: begin
        if (beat && s_tlast) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (beat && s_tkeep) begin
          req_addr_d = {req_addr_q[ADDR_WIDTH-9:0], s_tdata};
          hdr_cnt_d  = hdr_cnt_q + 3'd1;
          if (hdr_cnt_q == 3'(HDR_LEN - 2)) state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (beat && s_tkeep) begin
          req_len_d   = s_tdata;
          last_seen_d = s_tlast;
          word_d      = '0;
          req_valid_d = 1'b1;
          state_d     = ST_REQ;
        end else if (beat && s_tlast) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (req_ready) begin
          req_valid_d = 1'b0;
          if (!req_write_q) begin
            err_d   = !last_seen_q;
            state_d = last_seen_q ? ST_IDLE : ST_DROP;
          end else if (last_seen_q) begin
            // write packet ended on its header: close the burst with an empty word
            wr_valid_d = 1'b1;
            wr_last_d  = 1'b1;
            err_d      = 1'b1;
            state_d    = ST_WORD;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (beat) begin
          pk_push = s_tkeep;
          if (s_tlast) begin
            last_seen_d = 1'b1;
            wr_valid_d  = 1'b1;
            wr_last_d   = 1'b1;
            err_d       = !(pk_fill && last_word);
            state_d     = ST_WORD;
          end else if (pk_fill) begin
            wr_valid_d = 1'b1;
            wr_last_d  = last_word;
            state_d    = ST_WORD;
          end
        end
      end
      ST_WORD: begin
        if (wr_ready) begin
          wr_valid_d = 1'b0;
          wr_last_d  = 1'b0;
          pk_clr     = 1'b1;
          if (wr_last_q) begin
            err_d   = !last_seen_q;
            state_d = last_seen_q ? ST_IDLE : ST_DROP;
          end else begin
            word_d  = word_q + 8'd1;
            state_d = ST_DATA;
          end
        end
      end
      ST_DROP: begin
        if (beat && s_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    s_tready_d = !(state_d inside {ST_REQ, ST_WORD});
  end

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_IDLE;
      s_tready_q  <= 1'b0;
      hdr_cnt_q   <= '0;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_len_q   <= '0;
      wr_valid_q  <= 1'b0;
      wr_last_q   <= 1'b0;
      word_q      <= '0;
      last_seen_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_tready_q  <= s_tready_d;
      hdr_cnt_q   <= hdr_cnt_d;
      req_valid_q <= req_valid_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_len_q   <= req_len_d;
      wr_valid_q  <= wr_valid_d;
      wr_last_q   <= wr_last_d;
      word_q      <= word_d;
      last_seen_q <= last_seen_d;
      err_q       <= err_d;
    end
  end

`ifdef CMD_PARSER_STATS_EN
  logic [15:0] cmd_cnt_q, cmd_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    cmd_cnt_d = sat_inc(cmd_cnt_q, req_valid_q && req_ready);
    err_cnt_d = sat_inc(err_cnt_q, err_q);
  end

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      cmd_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      cmd_cnt_q <= cmd_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign cmd_count_o = cmd_cnt_q;
  assign err_count_o = err_cnt_q;
`else
  assign cmd_count_o = 16'd0;
  assign err_count_o = 16'd0;
`endif

  assign s_tready  = s_tready_q;
  assign req_valid = req_valid_q;
  assign req_write = req_write_q;
  assign req_addr  = req_addr_q;
  assign req_len   = req_len_q;
  assign wr_valid  = wr_valid_q;
  assign wr_last   = wr_last_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_ddr3_axis_cmd_parser.sv
// Scoreboard bench for ddr3_axis_cmd_parser: expected requests and write words are
// queued as packets are driven and compared when the DUT presents them.
module tb_ddr3_axis_cmd_parser;

  localparam int AW = 27;

  typedef struct packed { logic w; logic [AW-1:0] a; logic [7:0] l; } req_t;
  typedef struct packed { logic [31:0] d; logic [3:0] m; logic l; } wr_t;
  typedef logic [7:0] byte_q_t[$];

  logic          clock = 1'b0;
  logic          arst_n = 1'b0;
  logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tkeep = 1'b1;
  logic [7:0]    s_tdata = 8'h00;
  logic          s_tready;
  logic          req_valid, req_write;
  logic          req_ready = 1'b1;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_len;
  logic          wr_valid, wr_last;
  logic          wr_ready = 1'b1;
  logic [3:0]    wr_mask;
  logic [31:0]   wr_data;
  logic          err_o;
  logic [15:0]   cmd_count_o, err_count_o;

  req_t    exp_req[$];
  wr_t     exp_wr[$];
  byte_q_t pkt;
  int      n_chk = 0, n_err = 0;
  int      err_seen = 0, exp_cmd = 0, exp_errs = 0;
  int      cyc = 0, hold = 0;
  logic    stall_mode = 1'b0;

  ddr3_axis_cmd_parser #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clock(clock), .arst_n(arst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tkeep(s_tkeep), .s_tdata(s_tdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_last(wr_last), .wr_mask(wr_mask), .wr_data(wr_data),
    .err_o(err_o), .cmd_count_o(cmd_count_o), .err_count_o(err_count_o)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Ready generator: free-running, or the stall profile (req held off 20 cycles, wr 1-of-3)
  initial begin
    forever begin
      @(posedge clock); #1;
      cyc++;
      if (stall_mode) begin
        if (req_valid && hold < 20) begin req_ready = 1'b0; hold++; end
        else req_ready = 1'b1;
        wr_ready = (cyc % 3 == 0);
      end else begin
        req_ready = 1'b1;
        wr_ready  = 1'b1;
      end
    end
  end

  // Scoreboard monitor: checks every cycle an output is valid, pops on handshake
  always @(negedge clock) begin
    if (arst_n) begin
      if (err_o) err_seen++;
      if (req_valid) begin
        logic have;
        have = (exp_req.size() != 0);
        check_val("req_expected", have, 1);
        check_val("req_stall_tready", s_tready, 0);
        if (have) begin
          check_val("req_write", req_write, exp_req[0].w);
          check_val("req_addr", req_addr, exp_req[0].a);
          check_val("req_len", req_len, exp_req[0].l);
          if (req_ready) void'(exp_req.pop_front());
        end
      end
      if (wr_valid) begin
        logic have;
        have = (exp_wr.size() != 0);
        check_val("wr_expected", have, 1);
        check_val("wr_stall_tready", s_tready, 0);
        if (have) begin
          check_val("wr_data", wr_data, exp_wr[0].d);
          check_val("wr_mask", wr_mask, exp_wr[0].m);
          check_val("wr_last", wr_last, exp_wr[0].l);
          if (wr_ready) void'(exp_wr.pop_front());
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic last, input logic keep);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = last; s_tkeep = keep;
    while (!acc && n < 300) begin
      @(negedge clock);
      acc = s_tready;
      @(posedge clock); #1;
      n++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = 1'b1;
    check_val("s_tready_wait", acc, 1);
  endtask

  task automatic send_pkt(input byte_q_t b, input logic with_last);
    for (int i = 0; i < b.size(); i++)
      send_byte(b[i], with_last && (i == b.size() - 1), 1'b1);
  endtask

  task automatic push_req(input logic w, input logic [AW-1:0] a, input logic [7:0] l);
    req_t r;
    r.w = w; r.a = a; r.l = l;
    exp_req.push_back(r);
    exp_cmd++;
  endtask

  task automatic push_wr(input logic [31:0] d, input logic [3:0] m, input logic l);
    wr_t x;
    x.d = d; x.m = m; x.l = l;
    exp_wr.push_back(x);
  endtask

  task automatic end_test(input string tag, input int want_err);
    int n;
    n = 0;
    while ((exp_req.size() + exp_wr.size()) != 0 && n < 300) begin
      @(posedge clock); n++;
    end
    repeat (5) @(posedge clock);
    #1;
    exp_errs += want_err;
    check_val({tag, "_drained"}, exp_req.size() + exp_wr.size(), 0);
    check_val({tag, "_err_pulses"}, err_seen, want_err);
`ifdef CMD_PARSER_STATS_EN
    check_val({tag, "_cmd_count"}, cmd_count_o, exp_cmd);
    check_val({tag, "_err_count"}, err_count_o, exp_errs);
`else
    check_val({tag, "_cmd_count"}, cmd_count_o, 0);
    check_val({tag, "_err_count"}, err_count_o, 0);
`endif
    err_seen = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_s_tready"}, s_tready, 0);
    check_val({tag, "_req_valid"}, req_valid, 0);
    check_val({tag, "_req_fields"}, {req_write, req_addr, req_len}, 0);
    check_val({tag, "_wr_valid"}, wr_valid, 0);
    check_val({tag, "_wr_last"}, wr_last, 0);
    check_val({tag, "_wr_data"}, wr_data, 0);
    check_val({tag, "_wr_mask"}, wr_mask, 0);
    check_val({tag, "_err_o"}, err_o, 0);
    check_val({tag, "_counts"}, {cmd_count_o, err_count_o}, 0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_reset_outputs("rst");
    arst_n = 1'b1;
    @(posedge clock); #1;

    // Basic two-word write
    push_req(1'b1, 27'h100, 8'd1);
    push_wr(32'h44332211, 4'hF, 1'b0);
    push_wr(32'h88776655, 4'hF, 1'b1);
    pkt = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01,
            8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_pkt(pkt, 1'b1);
    end_test("write2", 0);

    // Read with tlast on the LEN byte
    push_req(1'b0, 27'h40, 8'd7);
    pkt = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h40, 8'h07};
    send_pkt(pkt, 1'b1);
    end_test("read", 0);

    // Write truncated after 6 payload bytes
    push_req(1'b1, 27'h200, 8'd1);
    push_wr(32'hA4A3A2A1, 4'hF, 1'b0);
    push_wr(32'h0000A6A5, 4'b0011, 1'b1);
    pkt = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h01,
            8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    send_pkt(pkt, 1'b1);
    end_test("trunc", 1);

    // Unknown opcode, 10-byte packet dropped
    pkt = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    send_pkt(pkt, 1'b1);
    end_test("badop", 1);

    // Stalled request then 1-of-3 write ready
    hold = 0;
    stall_mode = 1'b1;
    push_req(1'b1, 27'h100, 8'd1);
    push_wr(32'h44332211, 4'hF, 1'b0);
    push_wr(32'h88776655, 4'hF, 1'b1);
    pkt = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01,
            8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_pkt(pkt, 1'b1);
    end_test("stall", 0);
    check_val("stall_hold_cycles", hold, 20);
    stall_mode = 1'b0;

    // Address wider than ADDR_WIDTH, keep=0 beat inside the payload
    push_req(1'b1, 27'h2BCDEF0, 8'd0);
    push_wr(32'h04030201, 4'hF, 1'b1);
    pkt = '{8'h01, 8'h0A, 8'hBC, 8'hDE, 8'hF0, 8'h00, 8'h01};
    send_pkt(pkt, 1'b0);
    send_byte(8'hEE, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b1);
    send_byte(8'h03, 1'b0, 1'b1);
    send_byte(8'h04, 1'b1, 1'b1);
    end_test("keep0", 0);

    // tlast on a word boundary with a word still due
    push_req(1'b1, 27'h8, 8'd1);
    push_wr(32'hD4D3D2D1, 4'hF, 1'b0);
    push_wr(32'h00000000, 4'h0, 1'b1);
    pkt = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h08, 8'h01, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
    send_pkt(pkt, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    end_test("boundary", 1);

    // tlast inside the address field
    pkt = '{8'h02, 8'h00, 8'h00};
    send_pkt(pkt, 1'b1);
    end_test("short_hdr", 1);

    // Reset in the middle of DATA, then a clean read
    push_req(1'b1, 27'h10, 8'd3);
    push_wr(32'hB4B3B2B1, 4'hF, 1'b0);
    pkt = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'h03, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
    send_pkt(pkt, 1'b0);
    end_test("pre_rst", 0);
    @(negedge clock);
    arst_n = 1'b0;
    #2;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clock);
    check_val("midrst_wr_valid_held", wr_valid, 0);
    arst_n = 1'b1;
    exp_cmd = 0;
    exp_errs = 0;
    err_seen = 0;
    push_req(1'b0, 27'h1234, 8'd0);
    pkt = '{8'h02, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00};
    send_pkt(pkt, 1'b1);
    end_test("post_rst", 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
